// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the MEM-stage load/store controller.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned STRB_W_DEF = DATA_W_DEF / 8;

    // dword accesses are only legal on a 64-bit bus; otherwise they count as misaligned
    function automatic logic addr_aligned(input size_e size, input logic [2:0] low,
                                          input logic dword_ok);
        logic ok;
        ok = 1'b1;
        case (size)
            SZ_BYTE:  ok = 1'b1;
            SZ_HALF:  ok = (low[0] == 1'b0);
            SZ_WORD:  ok = (low[1:0] == 2'b00);
            SZ_DWORD: ok = dword_ok && (low == 3'b000);
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// SRAM-like req/addr_ok/data_ok data bus between the MEM stage and memory.
interface mem_access_unit_if
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned SIZE_W = 2
);
    logic                  bus_req;
    logic                  bus_wr;
    logic [SIZE_W-1:0]     bus_size;
    logic [ADDR_W-1:0]     bus_addr;
    logic [DATA_W-1:0]     bus_wdata;
    logic [DATA_W/8-1:0]   bus_wstrb;
    logic                  bus_addr_ok;
    logic                  bus_data_ok;
    logic [DATA_W-1:0]     bus_rdata;

    modport master (
        output bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/mem_access_unit_load_align_ext.sv
// Combinational load alignment: shift read data down by the byte offset, then
// sign- or zero-extend the selected byte/half/word/dword.
module load_align_ext
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]            rdata_i,
    input  logic [$clog2(DATA_W/8)-1:0]  offset_i,
    input  size_e                        size_i,
    input  logic                         zext_i,
    output logic [DATA_W-1:0]            result_o
);
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic              sign;

    assign shifted = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        mask = '1;
        sign = shifted[DATA_W-1];
        case (size_i)
            SZ_BYTE: begin
                mask = DATA_W'(32'h0000_00FF);
                sign = shifted[7];
            end
            SZ_HALF: begin
                mask = DATA_W'(32'h0000_FFFF);
                sign = shifted[15];
            end
            SZ_WORD: begin
                mask = DATA_W'(32'hFFFF_FFFF);
                sign = shifted[31];
            end
            default: begin
                mask = '1;
                sign = shifted[DATA_W-1];
            end
        endcase
        result_o = (shifted & mask) | ((sign && !zext_i) ? ~mask : '0);
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: issues one bus transaction per access,
// stalls the pipeline until it completes, and aligns/extends load data.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned SIZE_W = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 mem_valid,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [SIZE_W-1:0]    data_size,
    input  logic                 data_ext_type,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic                 flush,
    mem_access_unit_if.master    bus,
    output logic                 mem_stall,
    output logic                 load_valid,
    output logic [DATA_W-1:0]    load_result,
    output logic                 exc_adel,
    output logic                 exc_ades
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);

    state_e              state_q, state_d;
    logic                cancel_q, cancel_d;
    logic                wr_q;
    size_e               size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                zext_q;
    logic [DATA_W-1:0]   load_result_q;

    size_e               size_in;
    logic                aligned;
    logic                idle_chk;
    logic                start;
    logic                is_store;
    logic                capture;
    logic [DATA_W-1:0]   wdata_rep;
    logic [STRB_W-1:0]   size_mask;
    logic [STRB_W-1:0]   strb_shift;
    logic [DATA_W-1:0]   load_ext;

    assign size_in  = size_e'(data_size[1:0]);
    assign aligned  = addr_aligned(size_in, addr[2:0], DATA_W == 64);
    // resetn gates the combinational outputs so they read as reset values during reset
    assign idle_chk = resetn && (state_q == S_IDLE) && mem_valid && !flush;
    assign start    = idle_chk && (mem_read || mem_write) && aligned;
    assign is_store = mem_write && !mem_read;
    assign exc_adel = idle_chk && mem_read && !aligned;
    assign exc_ades = idle_chk && is_store && !aligned;

    always_comb begin
        wdata_rep = wdata;
        size_mask = '1;
        case (size_in)
            SZ_BYTE: begin
                wdata_rep = {STRB_W{wdata[7:0]}};
                size_mask = STRB_W'(8'h01);
            end
            SZ_HALF: begin
                wdata_rep = {(DATA_W/16){wdata[15:0]}};
                size_mask = STRB_W'(8'h03);
            end
            SZ_WORD: begin
                wdata_rep = {(DATA_W/32){wdata[31:0]}};
                size_mask = STRB_W'(8'h0F);
            end
            default: begin
                wdata_rep = wdata;
                size_mask = '1;
            end
        endcase
    end

    assign strb_shift = size_mask << addr[OFF_W-1:0];

    load_align_ext #(
        .DATA_W (DATA_W)
    ) u_load_align_ext (
        .rdata_i  (bus.bus_rdata),
        .offset_i (addr_q[OFF_W-1:0]),
        .size_i   (size_q),
        .zext_i   (zext_q),
        .result_o (load_ext)
    );

    always_comb begin
        state_d    = state_q;
        cancel_d   = cancel_q;
        mem_stall  = 1'b0;
        load_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                mem_stall = start;
                cancel_d  = 1'b0;
                if (start) state_d = S_REQ;
            end
            S_REQ: begin
                mem_stall = 1'b1;
                if (flush) cancel_d = 1'b1;
                if (bus.bus_addr_ok) state_d = S_WAIT;
            end
            S_WAIT: begin
                mem_stall = 1'b1;
                if (flush) cancel_d = 1'b1;
                if (bus.bus_data_ok) state_d = (cancel_q || flush) ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                load_valid = !wr_q && !flush;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign capture = (state_q == S_WAIT) && bus.bus_data_ok && !cancel_q && !flush && !wr_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            cancel_q      <= 1'b0;
            wr_q          <= 1'b0;
            size_q        <= SZ_BYTE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            zext_q        <= 1'b0;
            load_result_q <= '0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            if (start) begin
                wr_q    <= is_store;
                size_q  <= size_in;
                addr_q  <= addr;
                wdata_q <= is_store ? wdata_rep : '0;
                wstrb_q <= is_store ? strb_shift : '0;
                zext_q  <= data_ext_type;
            end
            if (capture) load_result_q <= load_ext;
        end
    end

    assign bus.bus_req   = (state_q == S_REQ);
    assign bus.bus_wr    = wr_q;
    assign bus.bus_size  = SIZE_W'(size_q);
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_wstrb = wstrb_q;
    assign load_result   = load_result_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table of loads/stores against a cycle-driven
// bus responder, a load-result scoreboard, and flush/reset corner sequences.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid, mem_read, mem_write;
    logic [1:0]  data_size;
    logic        data_ext_type;
    logic [31:0] addr, wdata;
    logic        flush;
    logic        mem_stall, load_valid, exc_adel, exc_ades;
    logic [31:0] load_result;

    always #5 clk = ~clk;

    mem_access_unit_if #(.DATA_W(32), .ADDR_W(32), .SIZE_W(2)) bus_if ();

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .SIZE_W(2)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .mem_valid     (mem_valid),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .data_size     (data_size),
        .data_ext_type (data_ext_type),
        .addr          (addr),
        .wdata         (wdata),
        .flush         (flush),
        .bus           (bus_if),
        .mem_stall     (mem_stall),
        .load_valid    (load_valid),
        .load_result   (load_result),
        .exc_adel      (exc_adel),
        .exc_ades      (exc_ades)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        ext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int unsigned a_dly;
        int unsigned d_dly;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_result;
        logic        exp_adel;
        logic        exp_ades;
    } vec_t;

    vec_t        vecs[14];
    logic [31:0] sb[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] size,
                                input logic ext, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rdat, input int unsigned ad,
                                input int unsigned dd, input logic [3:0] ws,
                                input logic [31:0] ewd, input logic [31:0] eres,
                                input logic adel, input logic ades);
        vec_t v;
        v.rd = rd; v.wr = wr; v.size = size; v.ext = ext; v.addr = a; v.wdata = wd;
        v.rdata = rdat; v.a_dly = ad; v.d_dly = dd; v.exp_wstrb = ws; v.exp_wdata = ewd;
        v.exp_result = eres; v.exp_adel = adel; v.exp_ades = ades;
        return v;
    endfunction

    // Scoreboard side: every load_valid must match the oldest expected load result
    always @(negedge clk) begin
        if (resetn === 1'b1 && load_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_load_valid: got load_valid=1 result 0x%0h, expected none",
                         load_result);
            end else begin
                check("sb_load_result", load_result, sb.pop_front());
            end
        end
    end

    task automatic drive(input vec_t v);
        mem_valid     = 1'b1;
        mem_read      = v.rd;
        mem_write     = v.wr;
        data_size     = v.size;
        data_ext_type = v.ext;
        addr          = v.addr;
        wdata         = v.wdata;
    endtask

    task automatic run_access(input vec_t v, input logic flush_at_done);
        int unsigned stalls;
        stalls = 0;
        @(posedge clk); #1;
        drive(v);
        @(negedge clk);
        check("exc_adel", exc_adel, v.exp_adel);
        check("exc_ades", exc_ades, v.exp_ades);
        if (v.exp_adel || v.exp_ades) begin
            check("misaligned_stall", mem_stall, 1'b0);
            check("misaligned_req", bus_if.bus_req, 1'b0);
            @(negedge clk);
            check("misaligned_req_later", bus_if.bus_req, 1'b0);
            @(posedge clk); #1;
            mem_valid = 1'b0;
            return;
        end
        if (mem_stall === 1'b1) stalls++;
        if (v.rd && !flush_at_done) sb.push_back(v.exp_result);
        for (int c = 1; c <= int'(v.a_dly); c++) begin
            @(posedge clk); #1;
            bus_if.bus_addr_ok = (c == int'(v.a_dly));
            @(negedge clk);
            if (mem_stall === 1'b1) stalls++;
            check("bus_req_high", bus_if.bus_req, 1'b1);
            if (c == 1) begin
                check("bus_addr", bus_if.bus_addr, v.addr);
                check("bus_size", bus_if.bus_size, v.size);
                check("bus_wr", bus_if.bus_wr, v.wr & ~v.rd);
                check("bus_wstrb", bus_if.bus_wstrb, v.exp_wstrb);
                if (v.wr && !v.rd) check("bus_wdata", bus_if.bus_wdata, v.exp_wdata);
            end
        end
        for (int c = 1; c <= int'(v.d_dly); c++) begin
            @(posedge clk); #1;
            bus_if.bus_addr_ok = 1'b0;
            bus_if.bus_data_ok = (c == int'(v.d_dly));
            bus_if.bus_rdata   = (c == int'(v.d_dly)) ? v.rdata : 32'hDEAD_DEAD;
            @(negedge clk);
            if (mem_stall === 1'b1) stalls++;
            if (c == 1) check("bus_req_low_wait", bus_if.bus_req, 1'b0);
        end
        @(posedge clk); #1;
        bus_if.bus_data_ok = 1'b0;
        if (flush_at_done) flush = 1'b1;
        @(negedge clk);
        check("done_stall", mem_stall, 1'b0);
        check("done_load_valid", load_valid, v.rd & ~flush_at_done);
        check("stall_cycles", 64'(stalls), 64'(1 + v.a_dly + v.d_dly));
        @(posedge clk); #1;
        mem_valid = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        vec_t v;
        resetn = 1'b0; mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        data_size = 2'b00; data_ext_type = 1'b0; addr = '0; wdata = '0; flush = 1'b0;
        bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b0; bus_if.bus_rdata = '0;

        vecs[0]  = mk(1, 0, 2'b10, 0, 32'h1000, 32'h0,         32'h80FF_1234, 2, 3, 4'b0000, 32'h0,         32'h80FF_1234, 0, 0);
        vecs[1]  = mk(1, 0, 2'b00, 0, 32'h1003, 32'h0,         32'h8012_3456, 1, 1, 4'b0000, 32'h0,         32'hFFFF_FF80, 0, 0);
        vecs[2]  = mk(1, 0, 2'b00, 1, 32'h1003, 32'h0,         32'h8012_3456, 1, 2, 4'b0000, 32'h0,         32'h0000_0080, 0, 0);
        vecs[3]  = mk(0, 1, 2'b01, 0, 32'h2002, 32'h0000_BEEF, 32'h0,         1, 1, 4'b1100, 32'hBEEF_BEEF, 32'h0,         0, 0);
        vecs[4]  = mk(1, 0, 2'b10, 0, 32'h1002, 32'h0,         32'h0,         1, 1, 4'b0000, 32'h0,         32'h0,         1, 0);
        vecs[5]  = mk(0, 1, 2'b10, 0, 32'h1001, 32'h1111_2222, 32'h0,         1, 1, 4'b0000, 32'h0,         32'h0,         0, 1);
        vecs[6]  = mk(0, 1, 2'b00, 0, 32'h3002, 32'h1234_5678, 32'h0,         3, 1, 4'b0100, 32'h7878_7878, 32'h0,         0, 0);
        vecs[7]  = mk(0, 1, 2'b10, 0, 32'h4000, 32'hDEAD_BEEF, 32'h0,         1, 4, 4'b1111, 32'hDEAD_BEEF, 32'h0,         0, 0);
        vecs[8]  = mk(1, 0, 2'b01, 0, 32'h1002, 32'h0,         32'h8001_7FFF, 2, 2, 4'b0000, 32'h0,         32'hFFFF_8001, 0, 0);
        vecs[9]  = mk(1, 0, 2'b01, 1, 32'h1000, 32'h0,         32'h1234_F00D, 1, 1, 4'b0000, 32'h0,         32'h0000_F00D, 0, 0);
        vecs[10] = mk(1, 0, 2'b01, 0, 32'h1001, 32'h0,         32'h0,         1, 1, 4'b0000, 32'h0,         32'h0,         1, 0);
        vecs[11] = mk(1, 0, 2'b11, 0, 32'h1000, 32'h0,         32'h0,         1, 1, 4'b0000, 32'h0,         32'h0,         1, 0);
        vecs[12] = mk(1, 1, 2'b10, 0, 32'h1000, 32'h5555_5555, 32'h0BAD_F00D, 1, 1, 4'b0000, 32'h0,         32'h0BAD_F00D, 0, 0);
        vecs[13] = mk(1, 0, 2'b00, 0, 32'h1001, 32'h0,         32'h0000_7F00, 1, 1, 4'b0000, 32'h0,         32'h0000_007F, 0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bus_req", bus_if.bus_req, 1'b0);
        check("rst_mem_stall", mem_stall, 1'b0);
        check("rst_load_valid", load_valid, 1'b0);
        check("rst_load_result", load_result, 32'h0);
        check("rst_bus_wstrb", bus_if.bus_wstrb, 4'b0000);
        @(posedge clk); #1;
        resetn = 1'b1;

        for (int i = 0; i < 14; i++) run_access(vecs[i], 1'b0);

        // Load flushed in its DONE cycle must not report load_valid
        run_access(mk(1, 0, 2'b10, 0, 32'h1004, 32'h0, 32'h7777_7777, 1, 1,
                      4'b0000, 32'h0, 32'h7777_7777, 0, 0), 1'b1);

        // Flush while the request is pending: request held, response discarded
        v = mk(1, 0, 2'b01, 0, 32'h1000, 32'h0, 32'hFFFF_FFFF, 3, 2, 4'b0000, 32'h0, 32'h0, 0, 0);
        @(posedge clk); #1;
        drive(v);
        @(negedge clk);
        check("fr_start_stall", mem_stall, 1'b1);
        @(posedge clk); #1;
        flush = 1'b1; mem_valid = 1'b0;
        @(negedge clk);
        check("fr_req_c1", bus_if.bus_req, 1'b1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("fr_req_c2", bus_if.bus_req, 1'b1);
        @(posedge clk); #1;
        bus_if.bus_addr_ok = 1'b1;
        @(negedge clk);
        check("fr_req_c3", bus_if.bus_req, 1'b1);
        @(posedge clk); #1;
        bus_if.bus_addr_ok = 1'b0;
        @(negedge clk);
        check("fr_wait_req", bus_if.bus_req, 1'b0);
        check("fr_wait_stall", mem_stall, 1'b1);
        @(posedge clk); #1;
        bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = v.rdata;
        @(negedge clk);
        check("fr_resp_stall", mem_stall, 1'b1);
        @(posedge clk); #1;
        bus_if.bus_data_ok = 1'b0;
        @(negedge clk);
        check("fr_after_stall", mem_stall, 1'b0);
        check("fr_after_valid", load_valid, 1'b0);
        check("fr_after_req", bus_if.bus_req, 1'b0);
        @(negedge clk);
        check("fr_after_valid2", load_valid, 1'b0);

        // Reset asserted while waiting for the response
        v = mk(1, 0, 2'b10, 0, 32'h1000, 32'h0, 32'h1234_5678, 1, 1, 4'b0000, 32'h0, 32'h0, 0, 0);
        @(posedge clk); #1;
        drive(v);
        @(posedge clk); #1;
        bus_if.bus_addr_ok = 1'b1;
        @(posedge clk); #1;
        bus_if.bus_addr_ok = 1'b0;
        @(negedge clk);
        check("rw_wait_stall", mem_stall, 1'b1);
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        check("rw_bus_req", bus_if.bus_req, 1'b0);
        check("rw_mem_stall", mem_stall, 1'b0);
        check("rw_load_valid", load_valid, 1'b0);
        check("rw_load_result", load_result, 32'h0);
        check("rw_bus_addr", bus_if.bus_addr, 32'h0);
        check("rw_bus_wr", bus_if.bus_wr, 1'b0);
        @(posedge clk); #1;
        mem_valid = 1'b0;
        resetn    = 1'b1;
        @(posedge clk); #1;
        bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = v.rdata;
        @(negedge clk);
        check("rw_late_stall", mem_stall, 1'b0);
        check("rw_late_req", bus_if.bus_req, 1'b0);
        @(posedge clk); #1;
        bus_if.bus_data_ok = 1'b0;
        @(negedge clk);
        check("rw_late_valid", load_valid, 1'b0);
        run_access(mk(1, 0, 2'b10, 0, 32'h1000, 32'h0, 32'hCAFE_0001, 1, 2,
                      4'b0000, 32'h0, 32'hCAFE_0001, 0, 0), 1'b0);

        repeat (2) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store controller; the parametrised successor to the MEM-stage control decode.
- Takes decoded memRead/memWrite/data_size/data_ext_type plus address and store data from the EX/MEM register.
- Drives an SRAM-like req/addr_ok/data_ok data bus, generates byte strobes and replicated store data, checks alignment, and aligns/extends load data.
- Holds the pipeline with a stall until the access completes, and supports cancellation by an exception flush.

Parameters:
- DATA_W, 32, bus and register data width; 32 or 64 only.
- ADDR_W, 32, address width.
- SIZE_W, 2, width of the size code: 00 byte, 01 half, 10 word, 11 dword (dword legal only when DATA_W=64).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- mem_valid  in  1  the MEM-stage instruction is valid.
- mem_read  in  1  load.
- mem_write  in  1  store.
- data_size  in  SIZE_W  access size code.
- data_ext_type  in  1  1 = zero-extend load, 0 = sign-extend.
- addr  in  ADDR_W  effective address.
- wdata  in  DATA_W  store source register value.
- flush  in  1  exception/ERET flush; cancels the current access.
- bus_req  out  1  request valid.
- bus_wr  out  1  1 = write.
- bus_size  out  SIZE_W  access size.
- bus_addr  out  ADDR_W  access address.
- bus_wdata  out  DATA_W  store data replicated to every lane.
- bus_wstrb  out  DATA_W/8  byte enables; all 0 for reads.
- bus_addr_ok  in  1  request accepted.
- bus_data_ok  in  1  response valid.
- bus_rdata  in  DATA_W  read data.
- mem_stall  out  1  hold IF..MEM stages.
- load_valid  out  1  load_result is valid this cycle.
- load_result  out  DATA_W  aligned, extended load value.
- exc_adel  out  1  misaligned load.
- exc_ades  out  1  misaligned store.

Behaviour:
- Reset values: state IDLE; bus_req, mem_stall, load_valid, exc_* = 0; load_result = 0; bus_* registers = 0.
- Define start = mem_valid & (mem_read|mem_write) & aligned & !flush.
- Alignment rules:
  - half requires addr[0]=0; word requires addr[1:0]=0; dword requires addr[2:0]=0.
  - dword with DATA_W=32 is treated as misaligned.
  - mem_read and mem_write both high is illegal; read wins.
- exc_adel/exc_ades are combinational, asserted only in IDLE with mem_valid & !flush. A misaligned access never issues a request and never stalls.
- States:
  - IDLE: on start, latch bus_wr/bus_size/bus_addr/bus_wdata/bus_wstrb and ext type, then go to REQ. mem_stall = start (combinational).
  - REQ: bus_req=1 with all bus_* fields stable. On bus_addr_ok, go to WAIT. mem_stall=1.
  - WAIT: on bus_data_ok, capture the extended load into load_result and go to DONE (or IDLE if cancelled). mem_stall=1.
  - DONE: one cycle; load_valid=1 for loads, mem_stall=0 so the pipeline advances; then IDLE. No new start is accepted in DONE.
- Store data and strobes: byte data is replicated every 8 bits, half every 16 bits, word every 32 bits. wstrb is the size mask shifted left by addr[log2(DATA_W/8)-1:0]. Example (DATA_W=32): SB at offset 2 gives 0100; SH at offset 2 gives 1100; SW gives 1111.
- Load data: shift rdata right by offset*8, take the low 8/16/32/64 bits, then sign- or zero-extend per ext type.
- Store completion: a store finishes on bus_data_ok like a load, with load_valid=0.
- Flush handling:
  - Flush in REQ: bus_req stays high until bus_addr_ok (a request is never withdrawn). A cancelled flag is set; WAIT discards the data and returns to IDLE; mem_stall drops when the response arrives.
  - Flush in WAIT: set cancelled; same discard path.
  - Flush in DONE: load_valid is forced to 0.
- Bus rules: bus_data_ok in IDLE, REQ or DONE is ignored; the bus guarantees data_ok at least one cycle after addr_ok. One outstanding transaction only.
- Reset mid-transaction: return immediately to IDLE with all outputs at reset values; the in-flight response is lost.

Decomposition:
- Shared package: size codes (SZ_BYTE..SZ_DWORD), state encoding, a strobe-width localparam, and an align-check function.
- One natural sub-module, load_align_ext: combinational shift-and-extend of rdata by offset, size and ext type.

Test Plan:
- LW at 0x1000, addr_ok after 2 cycles, data_ok 3 cycles later with rdata 0x80FF_1234 -> stall high 6 cycles, then load_valid=1 and load_result=0x80FF_1234.
- LB at 0x1003 with rdata 0x8012_3456, ext=0 -> result 0xFFFF_FF80; LBU (ext=1) -> 0x0000_0080.
- SH at 0x2002, wdata 0x0000_BEEF -> bus_wstrb=1100, bus_wdata=0xBEEF_BEEF, bus_wr=1, load_valid=0 at completion.
- LW at 0x1002 -> exc_adel=1 the same cycle, bus_req never rises, mem_stall=0; SW at 0x1001 -> exc_ades=1.
- LH issued, flush in REQ with addr_ok delayed 3 cycles -> bus_req held until addr_ok, data discarded, load_valid never asserted, then IDLE.
- resetn pulled low in WAIT -> outputs at reset values immediately; a later data_ok is ignored; a new LW completes normally.
